// File: rtl/pcie_tx_arbiter_pkg.sv
// Shared types for the two-client PCIe TX arbiter: FSM encoding and client index.
package pcie_tx_arb_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  typedef logic client_idx_t;

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// TX bundle between two TLP clients, the arbiter and the PCIe core TX AXI-Stream port.
interface pcie_tx_arbiter_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
  logic                    c0_tx_req;
  logic                    c0_tx_ack;
  logic [C_DATA_WIDTH-1:0] c0_tx_tdata;
  logic [KEEP_WIDTH-1:0]   c0_tx_tkeep;
  logic [3:0]              c0_tx_tuser;
  logic                    c0_tx_tlast;
  logic                    c0_tx_tvalid;
  logic                    c0_tx_tready;

  logic                    c1_tx_req;
  logic                    c1_tx_ack;
  logic [C_DATA_WIDTH-1:0] c1_tx_tdata;
  logic [KEEP_WIDTH-1:0]   c1_tx_tkeep;
  logic [3:0]              c1_tx_tuser;
  logic                    c1_tx_tlast;
  logic                    c1_tx_tvalid;
  logic                    c1_tx_tready;

  logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata;
  logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep;
  logic [3:0]              s_axis_tx_tuser;
  logic                    s_axis_tx_tlast;
  logic                    s_axis_tx_tvalid;
  logic                    s_axis_tx_tready;

  // Arbiter side
  modport master (
    input  c0_tx_req, c0_tx_tdata, c0_tx_tkeep, c0_tx_tuser, c0_tx_tlast, c0_tx_tvalid,
    output c0_tx_ack, c0_tx_tready,
    input  c1_tx_req, c1_tx_tdata, c1_tx_tkeep, c1_tx_tuser, c1_tx_tlast, c1_tx_tvalid,
    output c1_tx_ack, c1_tx_tready,
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast, s_axis_tx_tvalid,
    input  s_axis_tx_tready
  );

  // Clients plus core side
  modport slave (
    output c0_tx_req, c0_tx_tdata, c0_tx_tkeep, c0_tx_tuser, c0_tx_tlast, c0_tx_tvalid,
    input  c0_tx_ack, c0_tx_tready,
    output c1_tx_req, c1_tx_tdata, c1_tx_tkeep, c1_tx_tuser, c1_tx_tlast, c1_tx_tvalid,
    input  c1_tx_ack, c1_tx_tready,
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast, s_axis_tx_tvalid,
    output s_axis_tx_tready
  );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Round-robin owner of the PCIe core TX stream for two clients; switches only on TLP
// boundaries and counts forwarded TLPs.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic               user_clk,
  input  logic               user_reset_n,
  input  logic               user_lnk_up,
  pcie_tx_arbiter_if.master  tx,
  output logic [31:0]        tx_pkt_count
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_GNT0 = GNT0;
  localparam logic [1:0] S_GNT1 = GNT1;

  logic [1:0]              state;
  client_idx_t             rr_last;
  logic                    in_pkt;
  client_idx_t             idle_pick;
  logic                    beat_acc;

  logic [C_DATA_WIDTH-1:0] mux_tdata;
  logic [KEEP_WIDTH-1:0]   mux_tkeep;
  logic [3:0]              mux_tuser;
  logic                    mux_tlast;
  logic                    mux_tvalid;
  logic                    c0_rdy;
  logic                    c1_rdy;

  // Zero-latency pass-through of the owning client; everything idles at zero otherwise.
  always_comb begin
    mux_tdata  = '0;
    mux_tkeep  = '0;
    mux_tuser  = '0;
    mux_tlast  = 1'b0;
    mux_tvalid = 1'b0;
    c0_rdy     = 1'b0;
    c1_rdy     = 1'b0;
    case (state)
      S_GNT0: begin
        mux_tdata  = tx.c0_tx_tdata;
        mux_tkeep  = tx.c0_tx_tkeep;
        mux_tuser  = tx.c0_tx_tuser;
        mux_tlast  = tx.c0_tx_tlast;
        mux_tvalid = tx.c0_tx_tvalid;
        c0_rdy     = tx.s_axis_tx_tready;
      end
      S_GNT1: begin
        mux_tdata  = tx.c1_tx_tdata;
        mux_tkeep  = tx.c1_tx_tkeep;
        mux_tuser  = tx.c1_tx_tuser;
        mux_tlast  = tx.c1_tx_tlast;
        mux_tvalid = tx.c1_tx_tvalid;
        c1_rdy     = tx.s_axis_tx_tready;
      end
      default: ;
    endcase
  end

  assign tx.s_axis_tx_tdata  = mux_tdata;
  assign tx.s_axis_tx_tkeep  = mux_tkeep;
  assign tx.s_axis_tx_tuser  = mux_tuser;
  assign tx.s_axis_tx_tlast  = mux_tlast;
  assign tx.s_axis_tx_tvalid = mux_tvalid;
  assign tx.c0_tx_tready     = c0_rdy;
  assign tx.c1_tx_tready     = c1_rdy;
  assign tx.c0_tx_ack        = (state == S_GNT0);
  assign tx.c1_tx_ack        = (state == S_GNT1);

  assign beat_acc  = mux_tvalid & tx.s_axis_tx_tready;
  // With both requesting, the client that was not granted last wins.
  assign idle_pick = (tx.c0_tx_req && tx.c1_tx_req) ? ~rr_last : tx.c1_tx_req;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state        <= S_IDLE;
      rr_last      <= 1'b1;
      in_pkt       <= 1'b0;
      tx_pkt_count <= '0;
    end else begin
      if (beat_acc) in_pkt <= ~mux_tlast;
      if (beat_acc && mux_tlast) tx_pkt_count <= tx_pkt_count + 32'd1;

      case (state)
        S_IDLE: begin
          if (user_lnk_up && (tx.c0_tx_req || tx.c1_tx_req)) begin
            state   <= idle_pick ? S_GNT1 : S_GNT0;
            rr_last <= idle_pick;
          end
        end
        S_GNT0: begin
          if (!tx.c0_tx_req && !in_pkt && !beat_acc) begin
            if (tx.c1_tx_req && user_lnk_up) begin
              state   <= S_GNT1;
              rr_last <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GNT1: begin
          if (!tx.c1_tx_req && !in_pkt && !beat_acc) begin
            if (tx.c0_tx_req && user_lnk_up) begin
              state   <= S_GNT0;
              rr_last <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: vector table for a single TLP plus grant-sequencing scenarios.
module tb_pcie_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        lnk_up;
  logic [31:0] pkt_count;
  int          checks;
  int          failures;
  logic [31:0] exp_cnt;

  pcie_tx_arbiter_if #(.C_DATA_WIDTH(64)) bus ();

  pcie_tx_arbiter #(.C_DATA_WIDTH(64)) dut (
    .user_clk     (clk),
    .user_reset_n (rst_n),
    .user_lnk_up  (lnk_up),
    .tx           (bus),
    .tx_pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        last;
    logic [63:0] data;
    logic        rdy;
    logic        e_vld;
    logic        e_last;
    logic [63:0] e_data;
    logic        e_c0rdy;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.c0_tx_req = 1'b0;
    bus.c1_tx_req = 1'b0;
    bus.c0_tx_tvalid = 1'b0;
    bus.c1_tx_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 32'd0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 32'd0;

    tbl[0] = '{1'b1, 1'b0, 64'h1111_1111_1111_1111, 1'b1, 1'b1, 1'b0, 64'h1111_1111_1111_1111, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 64'h2222_2222_2222_2222, 1'b0, 1'b1, 1'b0, 64'h2222_2222_2222_2222, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 64'h2222_2222_2222_2222, 1'b1, 1'b1, 1'b0, 64'h2222_2222_2222_2222, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 64'h3333_3333_3333_3333, 1'b1, 1'b1, 1'b1, 64'h3333_3333_3333_3333, 1'b1};

    lnk_up = 1'b1;
    rst_n  = 1'b0;
    bus.c0_tx_req = 1'b1;   bus.c1_tx_req = 1'b0;
    bus.c0_tx_tdata = 64'hAAAA_AAAA_AAAA_AAAA; bus.c0_tx_tkeep = 8'hFF;
    bus.c0_tx_tuser = 4'h0; bus.c0_tx_tlast = 1'b0; bus.c0_tx_tvalid = 1'b1;
    bus.c1_tx_tdata = 64'hDEAD_DEAD_DEAD_DEAD; bus.c1_tx_tkeep = 8'hFF;
    bus.c1_tx_tuser = 4'h5; bus.c1_tx_tlast = 1'b1; bus.c1_tx_tvalid = 1'b0;
    bus.s_axis_tx_tready = 1'b1;

    // Reset with c0 requesting and driving a beat: nothing may leak out
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack0", bus.c0_tx_ack, 0);
    chk("rst_ack1", bus.c1_tx_ack, 0);
    chk("rst_tvalid", bus.s_axis_tx_tvalid, 0);
    chk("rst_tdata", bus.s_axis_tx_tdata, 0);
    chk("rst_tkeep", bus.s_axis_tx_tkeep, 0);
    chk("rst_c0_tready", bus.c0_tx_tready, 0);
    chk("rst_count", pkt_count, 0);
    rst_n = 1'b1;
    bus.c0_tx_tvalid = 1'b0;
    #1;
    chk("rel_ack0_same_cycle", bus.c0_tx_ack, 0);
    @(negedge clk); #1;
    chk("rel_ack0_next_cycle", bus.c0_tx_ack, 1);
    chk("rel_count", pkt_count, 0);

    // Three-beat TLP from client 0, core tready 1,0,1,1; c1 drives junk the whole time
    bus.c1_tx_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.c0_tx_tvalid = tbl[i].vld;
      bus.c0_tx_tlast  = tbl[i].last;
      bus.c0_tx_tdata  = tbl[i].data;
      bus.s_axis_tx_tready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_tvalid", i), bus.s_axis_tx_tvalid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_tlast", i), bus.s_axis_tx_tlast, tbl[i].e_last);
      chk($sformatf("tbl%0d_tdata", i), bus.s_axis_tx_tdata, tbl[i].e_data);
      chk($sformatf("tbl%0d_tkeep", i), bus.s_axis_tx_tkeep, 8'hFF);
      chk($sformatf("tbl%0d_c0_tready", i), bus.c0_tx_tready, tbl[i].e_c0rdy);
      chk($sformatf("tbl%0d_c1_tready", i), bus.c1_tx_tready, 0);
    end
    exp_cnt = 32'd1;
    @(negedge clk);
    bus.c0_tx_tvalid = 1'b0; bus.c0_tx_tlast = 1'b0; bus.c0_tx_req = 1'b0;
    #1;
    chk("tlp_count", pkt_count, exp_cnt);
    chk("tlp_ack0_hold", bus.c0_tx_ack, 1);
    @(negedge clk); #1;
    chk("idle_ack0", bus.c0_tx_ack, 0);
    chk("idle_no_fwd_tvalid", bus.s_axis_tx_tvalid, 0);
    chk("idle_no_fwd_tdata", bus.s_axis_tx_tdata, 0);
    chk("idle_c1_tready", bus.c1_tx_tready, 0);
    bus.c1_tx_tvalid = 1'b0;

    // Simultaneous requests and round-robin alternation
    do_reset();
    @(negedge clk);
    bus.c0_tx_req = 1'b1; bus.c1_tx_req = 1'b1;
    #1;
    chk("both_ack0_same_cycle", bus.c0_tx_ack, 0);
    @(negedge clk); #1;
    chk("both_first_ack0", bus.c0_tx_ack, 1);
    chk("both_first_ack1", bus.c1_tx_ack, 0);
    bus.c0_tx_req = 1'b0;
    @(negedge clk); #1;
    chk("handoff_ack0", bus.c0_tx_ack, 0);
    chk("handoff_ack1", bus.c1_tx_ack, 1);
    bus.c1_tx_req = 1'b0;
    @(negedge clk); #1;
    chk("idle2_ack0", bus.c0_tx_ack, 0);
    chk("idle2_ack1", bus.c1_tx_ack, 0);
    bus.c0_tx_req = 1'b1; bus.c1_tx_req = 1'b1;
    @(negedge clk); #1;
    chk("alt2_ack0", bus.c0_tx_ack, 1);
    chk("alt2_ack1", bus.c1_tx_ack, 0);
    bus.c0_tx_req = 1'b0; bus.c1_tx_req = 1'b0;
    @(negedge clk); #1;
    chk("idle3_ack0", bus.c0_tx_ack, 0);
    bus.c0_tx_req = 1'b1; bus.c1_tx_req = 1'b1;
    @(negedge clk); #1;
    chk("alt3_ack1", bus.c1_tx_ack, 1);
    chk("alt3_ack0", bus.c0_tx_ack, 0);

    // c0 drops req after beat 1 of a 4-beat TLP while c1 waits
    bus.c0_tx_req = 1'b0; bus.c1_tx_req = 1'b0;
    @(negedge clk); #1;
    chk("pre_mid_idle", bus.c1_tx_ack, 0);
    bus.c0_tx_req = 1'b1;
    @(negedge clk); #1;
    chk("mid_grant0", bus.c0_tx_ack, 1);
    @(negedge clk);
    bus.c1_tx_req = 1'b1;
    bus.c1_tx_tvalid = 1'b1; bus.c1_tx_tdata = 64'hC1C1_C1C1_C1C1_C1C1; bus.c1_tx_tlast = 1'b1;
    bus.c0_tx_tvalid = 1'b1; bus.c0_tx_tlast = 1'b0; bus.c0_tx_tdata = 64'h0101_0101_0101_0101;
    bus.s_axis_tx_tready = 1'b1;
    #1;
    chk("mid_beat1_tdata", bus.s_axis_tx_tdata, 64'h0101_0101_0101_0101);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      bus.c0_tx_req   = 1'b0;
      bus.c0_tx_tdata = {8{8'(k)}};
      bus.c0_tx_tlast = (k == 4);
      #1;
      chk($sformatf("mid_beat%0d_ack0", k), bus.c0_tx_ack, 1);
      chk($sformatf("mid_beat%0d_ack1", k), bus.c1_tx_ack, 0);
      chk($sformatf("mid_beat%0d_tdata", k), bus.s_axis_tx_tdata, {8{8'(k)}});
    end
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    bus.c0_tx_tvalid = 1'b0; bus.c0_tx_tlast = 1'b0;
    bus.s_axis_tx_tready = 1'b0;
    #1;
    chk("mid_after_last_ack0", bus.c0_tx_ack, 1);
    chk("mid_after_last_ack1", bus.c1_tx_ack, 0);
    chk("mid_count", pkt_count, exp_cnt);
    @(negedge clk); #1;
    chk("mid_switch_ack0", bus.c0_tx_ack, 0);
    chk("mid_switch_ack1", bus.c1_tx_ack, 1);
    chk("mid_switch_tdata", bus.s_axis_tx_tdata, 64'hC1C1_C1C1_C1C1_C1C1);

    // Link down blocks new grants
    bus.c1_tx_req = 1'b0; bus.c1_tx_tvalid = 1'b0;
    @(negedge clk);
    lnk_up = 1'b0; bus.c1_tx_req = 1'b1;
    #1;
    chk("lnk_idle_ack1", bus.c1_tx_ack, 0);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk); #1;
      chk($sformatf("lnk_down_ack1_c%0d", j), bus.c1_tx_ack, 0);
    end
    lnk_up = 1'b1;
    #1;
    chk("lnk_up_same_cycle", bus.c1_tx_ack, 0);
    @(negedge clk); #1;
    chk("lnk_up_grant1", bus.c1_tx_ack, 1);

    // Counter wrap on a single-beat TLP
    force dut.tx_pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.tx_pkt_count;
    #1;
    chk("wrap_preload", pkt_count, 32'hFFFF_FFFF);
    bus.c1_tx_tvalid = 1'b1; bus.c1_tx_tlast = 1'b1;
    bus.c1_tx_tdata = 64'h5555_5555_5555_5555;
    bus.s_axis_tx_tready = 1'b1;
    #1;
    chk("wrap_tlast", bus.s_axis_tx_tlast, 1);
    chk("wrap_c1_tready", bus.c1_tx_tready, 1);
    @(posedge clk); #1;
    bus.c1_tx_tvalid = 1'b0;
    chk("wrap_count", pkt_count, 32'd0);
    chk("wrap_in_pkt", dut.in_pkt, 0);
    @(negedge clk); #1;
    chk("wrap_in_pkt_after", dut.in_pkt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
- Sits between the 7-series PCIe core TX AXI-Stream port and two TLP-producing application clients.
- Grants the TX port to one client at a time using the per-client req/ack handshake that the app blocks drive (s_axis_tx_req / s_axis_tx_ack).
- Muxes the granted client's stream onto the core and never switches clients mid-TLP.
- Round-robin fairness, plus a forwarded-packet counter for debug registers.

Parameters:
- C_DATA_WIDTH, 64, TX stream data width.
- KEEP_WIDTH, C_DATA_WIDTH/8, byte-enable width.

Ports:
- user_clk  in  1  core user clock; the only clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- user_lnk_up  in  1  PCIe link up.
- c0_tx_req / c1_tx_req  in  1  client requests TX ownership.
- c0_tx_ack / c1_tx_ack  out  1  client owns TX (registered).
- cN_tx_tdata  in  C_DATA_WIDTH  client N data.
- cN_tx_tkeep  in  KEEP_WIDTH  client N byte enables.
- cN_tx_tuser  in  4  client N tuser.
- cN_tx_tlast  in  1  client N end of TLP.
- cN_tx_tvalid  in  1  client N beat valid.
- cN_tx_tready  out  1  client N ready.
- s_axis_tx_tdata  out  C_DATA_WIDTH  to core.
- s_axis_tx_tkeep  out  KEEP_WIDTH  to core.
- s_axis_tx_tuser  out  4  to core.
- s_axis_tx_tlast  out  1  to core.
- s_axis_tx_tvalid  out  1  to core.
- s_axis_tx_tready  in  1  from core.
- tx_pkt_count  out  32  TLPs forwarded (tlast handshakes), wraps.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, c0_tx_ack=c1_tx_ack=0, rr_last=1 (client 0 has first priority), in_pkt=0, tx_pkt_count=0.
  - All s_axis_tx_* outputs 0; both cN_tx_tready=0.
- States: IDLE, GNT0, GNT1. ackN = (state==GNTN), decoded from a register; no combinational path from req to ack.
- IDLE:
  - If user_lnk_up and any req: grant the requester not equal to rr_last; if only one requests, grant it.
  - Set rr_last to the granted index.
  - Latency: req high in cycle n -> ack high in cycle n+1.
  - No grant while user_lnk_up=0.
- GNTN datapath (combinational pass-through, zero added latency):
  - s_axis_tx_* = cN_tx_*.
  - cN_tx_tready = s_axis_tx_tready.
  - The other client's tready=0.
- Not granted: s_axis_tx_tvalid/tlast/tdata/tkeep/tuser driven 0. A non-granted client's tvalid is ignored and never forwarded.
- in_pkt tracking:
  - Set on an accepted beat (tvalid&tready) with tlast=0.
  - Cleared on an accepted beat with tlast=1.
  - A single-beat TLP never sets it.
- Release from GNTN when cN_tx_req=0 and in_pkt=0 and no beat is being accepted that cycle:
  - If the other client requests and user_lnk_up: go directly to GNT(other), set rr_last. ackN falls and ack(other) rises in the same cycle (n+1).
  - Otherwise go to IDLE.
- Client drops req mid-TLP (in_pkt=1): grant holds until the tlast beat is accepted, then release is evaluated the following cycle.
- A client may send any number of TLPs under one grant while holding req.
- user_lnk_up falling during a grant: grant held; behaviour unchanged (the core deasserts tready). Only new grants are blocked.
- tx_pkt_count increments by 1 on each tvalid&tready&tlast at the core port. It is 32-bit modulo: 0xFFFFFFFF -> 0.
- Simultaneous req from both in IDLE: alternate strictly; the winner is the one not in rr_last.
- tvalid without an active grant/req is a client protocol error. The block still never forwards it.

Decomposition:
- Shared package pcie_tx_arb_pkg:
  - typedef enum state_t {IDLE, GNT0, GNT1}.
  - typedef client_idx_t (1 bit).
  - localparam NUM_CLIENTS=2.
- No sub-module. Mux and FSM live in one file; a separate mux module is unnecessary at two clients.

Test Plan:
- Reset with c0_tx_req=1 held -> all outputs 0 during reset; after release c0_tx_ack=1 exactly one cycle later; tx_pkt_count=0.
- Client 0 sends a 3-beat TLP (tdata 0x1111..., 0x2222..., 0x3333..., tkeep 0xFF) with tready toggling 1,0,1,1 -> core sees identical beats in order; c1_tx_tready stays 0; tx_pkt_count=1.
- Both reqs rise in the same cycle from reset -> client 0 granted first. On c0 release with c1 still requesting, ack0 falls and ack1 rises in the same cycle. Next contention after both release -> client 0 (alternation) again.
- c0_tx_req dropped after beat 1 of a 4-beat TLP while c1 requests -> c0_tx_ack stays high until beat 4 is accepted, c1_tx_ack rises the cycle after that; no interleaved beats.
- user_lnk_up=0 with c1_tx_req=1 -> no ack for 20 cycles; link up -> c1_tx_ack next cycle.
- Preload-free wrap: force 0xFFFFFFFF via long run or backdoor, send one single-beat TLP -> tx_pkt_count=0; in_pkt never set.
